// File: rtl/prog_sequencer.sv
// prog_sequencer
// ----------------------------------------------------------------------------
// Program-execution controller. It owns the program counter and runs a program
// from Start to Done. In each RUN cycle it holds, steps or branches the PC
// based on the datapath's stall, halt and branch/flag inputs. It also counts
// retired instructions and stops the run after a cycle budget (watchdog).
//
// Ports
//   Clk, Reset    : clock, synchronous active-high reset
//   Start         : run request, sampled in IDLE and DONE, ignored in RUN
//   Stall         : datapath not ready, so the instruction at PC does not retire
//   HaltInstr     : instruction at PC is a halt
//   BranchRel     : instruction at PC is a relative (backward) branch
//   Zero          : ALU zero flag; the branch is taken only when Zero=0
//   Target        : backward branch distance
//   PC            : current instruction address (registered)
//   Running       : high while in RUN
//   Retire        : combinational, instruction at PC completes this cycle
//   Done, Timeout : level outputs, valid while in DONE
//   InstrCount    : instructions retired in the current or last run (saturating)
//   o_dbg_state   : current FSM state, for observation only
//
// Handshake: Start is a level request with no ready. Any cycle in IDLE or DONE
// with Start=1 launches a run on that edge. Done stays high until the next
// launching Start or Reset.
// ----------------------------------------------------------------------------
module prog_sequencer #(
  parameter int W          = 8,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 1000,
  parameter int START_ADDR = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          HaltInstr,
  input  logic          BranchRel,
  input  logic          Zero,
  input  logic [W-1:0]  Target,
  output logic [W-1:0]  PC,
  output logic          Running,
  output logic          Retire,
  output logic          Done,
  output logic          Timeout,
  output logic [CW-1:0] InstrCount,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0]  START_PC = W'(START_ADDR);
  localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        r_state;
  logic [W-1:0]  r_pc;
  logic [CW-1:0] r_instr_cnt;
  logic [CW-1:0] r_cyc_cnt;
  logic          r_done;
  logic          r_timeout;

  logic          w_budget_hit;
  logic          w_retire;
  logic [CW-1:0] w_instr_inc;
  logic [CW-1:0] w_cyc_inc;
  logic [W-1:0]  w_pc_next;

  // The compare is ">=" rather than "==". A stall on the last budget cycle
  // therefore defers the forced stop to the next unstalled cycle instead of
  // letting the counter run past the budget forever.
  assign w_budget_hit = (r_cyc_cnt >= LAST_CYC);
  assign w_retire     = (r_state == ST_RUN) && !Reset && !Stall &&
                        (HaltInstr || !w_budget_hit);
  assign w_instr_inc  = (r_instr_cnt == CNT_MAX) ? r_instr_cnt : r_instr_cnt + CW'(1);
  assign w_cyc_inc    = (r_cyc_cnt == CNT_MAX) ? r_cyc_cnt : r_cyc_cnt + CW'(1);
  // Unsigned W-bit arithmetic, so both directions wrap modulo 2^W.
  assign w_pc_next    = (BranchRel && !Zero) ? (r_pc - Target) : (r_pc + W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= START_PC;
      r_instr_cnt <= '0;
      r_cyc_cnt   <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state     <= ST_RUN;
            r_pc        <= START_PC;
            r_instr_cnt <= '0;
            r_cyc_cnt   <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cyc_cnt <= w_cyc_inc;
          if (!Stall) begin
            if (HaltInstr) begin
              // The halt retires and PC keeps pointing at it.
              r_instr_cnt <= w_instr_inc;
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
            end else if (w_budget_hit) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end else begin
              r_instr_cnt <= w_instr_inc;
              r_pc        <= w_pc_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign PC          = r_pc;
  assign Running     = (r_state == ST_RUN);
  assign Retire      = w_retire;
  assign Done        = r_done;
  assign Timeout     = r_timeout;
  assign InstrCount  = r_instr_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer. Two instances share the same inputs:
//   dut0: START_ADDR=0,   MAX_CYCLES=20
//   dut1: START_ADDR=254, MAX_CYCLES=30 (exercises PC wrap-around)
// A behavioural model tracks each instance from the run rules. Directed
// scenarios come first and then a randomized phase. Every output is checked
// on every cycle.
module tb_prog_sequencer;

  localparam int W  = 8;
  localparam int CW = 16;

  // Clock and reset block
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         Reset, Start, Stall, HaltInstr, BranchRel, Zero;
  logic [W-1:0] Target;

  logic [W-1:0]  pc_0, pc_1;
  logic          run_0, run_1, ret_0, ret_1, done_0, done_1, to_0, to_1;
  logic [CW-1:0] cnt_0, cnt_1;
  logic [1:0]    dbg_0, dbg_1;

  prog_sequencer #(.W(W), .CW(CW), .MAX_CYCLES(20), .START_ADDR(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .HaltInstr(HaltInstr), .BranchRel(BranchRel), .Zero(Zero), .Target(Target),
    .PC(pc_0), .Running(run_0), .Retire(ret_0), .Done(done_0),
    .Timeout(to_0), .InstrCount(cnt_0), .o_dbg_state(dbg_0)
  );

  prog_sequencer #(.W(W), .CW(CW), .MAX_CYCLES(30), .START_ADDR(254)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .HaltInstr(HaltInstr), .BranchRel(BranchRel), .Zero(Zero), .Target(Target),
    .PC(pc_1), .Running(run_1), .Retire(ret_1), .Done(done_1),
    .Timeout(to_1), .InstrCount(cnt_1), .o_dbg_state(dbg_1)
  );

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int ret_seen_0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one entry per instance
  int m_start[2] = '{0, 254};
  int m_max[2]   = '{20, 30};
  int m_pc[2], m_cnt[2], m_cyc[2];
  bit m_run[2], m_done[2], m_to[2];

  function automatic bit model_retire(int i, bit rst, bit sl, bit h);
    return m_run[i] && !rst && !sl && (h || (m_cyc[i] < m_max[i] - 1));
  endfunction

  task automatic model_update(int i, bit rst, bit st, bit sl, bit h, bit b, bit z, int tg);
    bit over;
    if (rst) begin
      m_run[i] = 0; m_done[i] = 0; m_to[i] = 0;
      m_pc[i] = m_start[i]; m_cnt[i] = 0; m_cyc[i] = 0;
    end else if (!m_run[i]) begin
      if (st) begin
        m_run[i] = 1; m_done[i] = 0; m_to[i] = 0;
        m_pc[i] = m_start[i]; m_cnt[i] = 0; m_cyc[i] = 0;
      end
    end else begin
      over = (m_cyc[i] >= m_max[i] - 1);
      if (m_cyc[i] < 65535) m_cyc[i]++;
      if (!sl) begin
        if (h) begin
          if (m_cnt[i] < 65535) m_cnt[i]++;
          m_run[i] = 0; m_done[i] = 1;
        end else if (over) begin
          m_run[i] = 0; m_done[i] = 1; m_to[i] = 1;
        end else begin
          if (m_cnt[i] < 65535) m_cnt[i]++;
          if (b && !z) m_pc[i] = (m_pc[i] - tg) & 255;
          else         m_pc[i] = (m_pc[i] + 1) & 255;
        end
      end
    end
  endtask

  // Driver: apply one cycle of inputs, check Retire before the edge and the
  // registered outputs half a cycle after it.
  task automatic step(input bit rst, input bit st, input bit sl, input bit h,
                      input bit b, input bit z, input int tg);
    bit er0, er1;
    Reset = rst; Start = st; Stall = sl; HaltInstr = h;
    BranchRel = b; Zero = z; Target = tg[W-1:0];
    #1;
    er0 = model_retire(0, rst, sl, h);
    er1 = model_retire(1, rst, sl, h);
    chk("retire0", ret_0, er0);
    chk("retire1", ret_1, er1);
    if (ret_0 === 1'b1) ret_seen_0++;
    @(posedge Clk);
    model_update(0, rst, st, sl, h, b, z, tg);
    model_update(1, rst, st, sl, h, b, z, tg);
    exp_q.push_back(m_pc[0][W-1:0]);
    @(negedge Clk);
    chk("pc0",    pc_0, exp_q.pop_front());
    chk("run0",   run_0, m_run[0]);
    chk("done0",  done_0, m_done[0]);
    chk("to0",    to_0, m_to[0]);
    chk("cnt0",   cnt_0, m_cnt[0]);
    chk("pc1",    pc_1, m_pc[1]);
    chk("run1",   run_1, m_run[1]);
    chk("done1",  done_1, m_done[1]);
    chk("to1",    to_1, m_to[1]);
    chk("cnt1",   cnt_1, m_cnt[1]);
  endtask

  task automatic plain(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1; Start = 0; Stall = 0; HaltInstr = 0; BranchRel = 0; Zero = 0; Target = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc0", pc_0, 0);
    chk("rst_pc1", pc_1, 254);
    chk("rst_done0", done_0, 0);
    chk("rst_cnt0", cnt_0, 0);

    // Straight run, halt at PC=5
    ret_seen_0 = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t1_run", run_0, 1);
    chk("t1_pc_start", pc_0, 0);
    plain(5);
    chk("t1_pc5", pc_0, 5);
    chk("t1_pc_wrap1", pc_1, 3);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t1_done", done_0, 1);
    chk("t1_running", run_0, 0);
    chk("t1_count", cnt_0, 6);
    chk("t1_pc_halt", pc_0, 5);
    chk("t1_timeout", to_0, 0);
    chk("t1_retires", ret_seen_0, 6);

    // Branch taken and not taken at PC=10
    step(0, 1, 0, 0, 0, 0, 0);
    plain(10);
    chk("t2_pc10", pc_0, 10);
    step(0, 0, 0, 0, 1, 0, 3);
    chk("t2_taken", pc_0, 7);
    chk("t2_cnt", cnt_0, 11);
    plain(3);
    step(0, 0, 0, 0, 1, 1, 3);
    chk("t2_not_taken", pc_0, 11);
    step(0, 0, 0, 1, 0, 0, 0);

    // Stall masks the halt
    step(0, 1, 0, 0, 0, 0, 0);
    plain(4);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0, 0, 0);
      chk("t3_stall_pc", pc_0, 4);
      chk("t3_stall_cnt", cnt_0, 4);
      chk("t3_stall_run", run_0, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_release", pc_0, 5);
    step(0, 0, 0, 1, 0, 0, 0);

    // Watchdog, then a halt on the final budget cycle
    step(0, 1, 0, 0, 0, 0, 0);
    plain(25);
    chk("t4_done", done_0, 1);
    chk("t4_timeout", to_0, 1);
    chk("t4_pc", pc_0, 19);
    chk("t4_cnt", cnt_0, 19);
    step(0, 1, 0, 0, 0, 0, 0);   // dut1 still in RUN: ignores Start
    chk("t4_restart_to", to_0, 0);
    plain(19);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t4_halt_done", done_0, 1);
    chk("t4_halt_to", to_0, 0);

    // Wrap from START_ADDR=254 and a branch that wraps below zero
    plain(10);                   // let dut1 reach DONE
    step(0, 1, 0, 0, 0, 0, 0);
    plain(4);
    chk("t5_pc2", pc_1, 2);
    step(0, 0, 0, 0, 1, 0, 5);
    chk("t5_branch", pc_1, 253);
    chk("t5_branch0", pc_0, 255);
    step(0, 0, 0, 1, 0, 0, 0);

    // Start in RUN is ignored, Reset mid-run, relaunch from DONE
    step(0, 1, 0, 0, 0, 0, 0);
    plain(3);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t6_no_restart", pc_0, 4);
    plain(3);
    chk("t6_pc7", pc_0, 7);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_pc", pc_0, 0);
    chk("t6_rst_cnt", cnt_0, 0);
    chk("t6_rst_done", done_0, 0);
    chk("t6_rst_run", run_0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    plain(25);                   // dut0 times out
    step(0, 1, 0, 0, 0, 0, 0);   // held Start relaunches dut0 from DONE
    chk("t6_relaunch_done", done_0, 0);
    chk("t6_relaunch_to", to_0, 0);
    chk("t6_relaunch_pc", pc_0, 0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0),
           int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Program-execution controller that owns the core's program counter and sequences a program run from Start to Done. Each cycle it decides to hold, step or branch the PC, based on stall, halt-decode and branch/flag inputs from the datapath. It also counts retired instructions and enforces a cycle-limit watchdog. It sits between the top-level test harness (Start/Done handshake) and the instruction ROM/decoder.

Parameters:
W, 8, PC width / instruction ROM address width
CW, 16, width of the instruction and cycle counters
MAX_CYCLES, 1000, RUN-state cycle budget before forced stop; legal range 1..2^CW-1
START_ADDR, 0, PC value loaded on reset and on every Start

Ports:
Clk  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  run request; sampled in IDLE and DONE, ignored in RUN
Stall  input  1  datapath not ready; current instruction does not retire
HaltInstr  input  1  decoder flags the instruction at PC as halt
BranchRel  input  1  decoder flags the instruction at PC as relative branch
Zero  input  1  ALU zero flag; branch taken only when Zero=0
Target  input  W  backward branch distance
PC  output  W  current instruction address (registered)
Running  output  1  high while in RUN (decoded from state)
Retire  output  1  combinational; high in RUN when the instruction at PC completes this cycle
Done  output  1  level; high in DONE until the next Start or Reset
Timeout  output  1  level; high in DONE when the run ended on the watchdog
InstrCount  output  CW  instructions retired in the current or last run, including the halt

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free, but no other reachable states are allowed.
- Reset (any state, including mid-run): state=IDLE, PC=START_ADDR, InstrCount=0, cycle counter=0, Done=0, Timeout=0. Reset overrides all other inputs.
- IDLE: PC holds. If Start=1: next state=RUN, PC<=START_ADDR, InstrCount<=0, cycle counter<=0, Done<=0, Timeout<=0.
- RUN: the cycle counter increments every RUN cycle, stalled or not. Priority order in each cycle:
  1. Stall=1: PC holds, InstrCount holds, Retire=0. HaltInstr and BranchRel are ignored.
  2. HaltInstr=1: Retire=1, InstrCount+1, PC holds (points at the halt), next state=DONE, Timeout stays 0. Halt wins even on the final budget cycle.
  3. Cycle counter==MAX_CYCLES-1: Retire=0, PC holds, InstrCount holds, next state=DONE, Timeout<=1.
  4. Otherwise Retire=1, InstrCount+1, and:
     - if BranchRel=1 and Zero=0: PC <= PC - Target, modulo 2^W.
     - otherwise: PC <= PC + 1, modulo 2^W.
- Arithmetic: all PC math is unsigned W-bit with wrap-around (255+1=0; 2-5=253 for W=8). A taken branch with Target=0 re-executes the same address and still retires.
- InstrCount saturates at 2^CW-1 and never wraps.
- DONE: PC, InstrCount and Timeout hold; Done=1. Start=1 restarts exactly as from IDLE, clearing Done and Timeout on the same edge.
- Start in RUN has no effect. Start held high across DONE immediately re-launches the next run.
- Latency: Start at edge n gives Running=1 after edge n, with the first instruction at PC=START_ADDR. Halt retires at edge m gives Done=1 after edge m.

Test Plan:
1. Reset, Start pulse, no stalls, no branches, HaltInstr=1 while PC==5 -> PC steps 0,1,2,3,4,5. Done=1 and Running=0 after the halt edge, InstrCount=6, Timeout=0, Retire high for 6 cycles.
2. Run to PC=10, drive BranchRel=1, Zero=0, Target=3 -> next PC=7, InstrCount+1. Repeat at PC=10 with Zero=1 -> next PC=11.
3. At PC=4, hold Stall=1 for 3 cycles with HaltInstr=1 also asserted -> PC stays 4, Retire=0, InstrCount unchanged, no halt taken. Release Stall with HaltInstr=0 -> PC=5.
4. MAX_CYCLES=20, no halt, no stall -> after 20 RUN cycles Done=1, Timeout=1, PC=19, InstrCount=19. Then apply HaltInstr=1 on cycle 20 of a fresh run -> Done=1 and Timeout=0.
5. START_ADDR=254 -> PC 254, 255, 0, 1, 2. At PC=2 take a branch with Target=5 -> PC=253.
6. Assert Reset mid-RUN at PC=7 -> IDLE, PC=START_ADDR, InstrCount=0, Done=0. Pulse Start during RUN -> no restart. Pulse Start in DONE -> new run from START_ADDR with Done and Timeout cleared.
